// File: rtl/event_encoder.sv
// -----------------------------------------------------------------------------
// event_encoder
//   Sequential N-to-log2(N) priority encoder. Each rising edge on a request
//   line is latched in a pending register. Pending events are presented one at
//   a time as a binary index on a valid/ready handshake. The lowest index has
//   the highest priority. An edge that arrives on a line that is already
//   pending is merged into that pending bit and raises a sticky overrun flag.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   en       in   1 = capture rising edges on req, 0 = ignore edges
//   req      in   [N] request lines, synchronous to clk
//   code     out  [W] index of the event being presented
//   valid    out  code is valid
//   ready    in   consumer accepts code when valid & ready at a clk edge
//   pending  out  [N] latched, not-yet-accepted events (includes presented one)
//   overrun  out  sticky: an edge arrived on a line that was already pending
//   clr_ovr  in   synchronous clear of overrun (a set in the same cycle wins)
// -----------------------------------------------------------------------------
module event_encoder #(
   parameter  int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [N-1:0] req,
   output logic [W-1:0] code,
   output logic         valid,
   input  logic         ready,
   output logic [N-1:0] pending,
   output logic         overrun,
   input  logic         clr_ovr
);

   // Index of the lowest set bit; the scan runs downward so the lowest index
   // is written last and wins.
   function automatic logic [W-1:0] lowest_idx(input logic [N-1:0] v);
      lowest_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (v[i]) lowest_idx = W'(i);
      end
   endfunction

   logic [N-1:0] req_q;
   logic [N-1:0] pending_q, pending_d;
   logic         valid_q,   valid_d;
   logic [W-1:0] code_q,    code_d;
   logic         overrun_q, overrun_d;

   logic [N-1:0] rise;
   logic [N-1:0] clr;
   logic [N-1:0] cand;
   logic         acc;
   logic         slot_free;

   always_comb begin
      rise      = {N{en}} & req & ~req_q;
      acc       = valid_q & ready;
      clr       = '0;
      for (int i = 0; i < N; i++) begin
         clr[i] = acc && (code_q == W'(i));
      end

      // A rise on the bit being accepted this cycle re-sets that bit: it is a
      // fresh event, not a duplicate, so it does not count as an overrun.
      pending_d = (pending_q & ~clr) | rise;

      if (|(rise & pending_q & ~clr)) begin
         overrun_d = 1'b1;
      end else if (clr_ovr) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end

      // Only registered pending feeds the output slot; this cycle's rises
      // become candidates one cycle later.
      slot_free = ~valid_q | acc;
      cand      = pending_q & ~clr;
      valid_d   = valid_q;
      code_d    = code_q;
      if (slot_free) begin
         if (|cand) begin
            valid_d = 1'b1;
            code_d  = lowest_idx(cand);
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // All ones so a line already high through reset is not an edge.
         req_q     <= '1;
         pending_q <= '0;
         valid_q   <= 1'b0;
         code_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         req_q     <= req;
         pending_q <= pending_d;
         valid_q   <= valid_d;
         code_q    <= code_d;
         overrun_q <= overrun_d;
      end
   end

   assign code    = code_q;
   assign valid   = valid_q;
   assign pending = pending_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_event_encoder.sv
module tb_event_encoder;

   localparam int N = 8;
   localparam int W = $clog2(N);

   logic         clk;
   logic         rst_n;
   logic         en;
   logic [N-1:0] req;
   logic [W-1:0] code;
   logic         valid;
   logic         ready;
   logic [N-1:0] pending;
   logic         overrun;
   logic         clr_ovr;

   int n_chk;
   int n_pass;

   event_encoder #(.N(N)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .req     (req),
      .code    (code),
      .valid   (valid),
      .ready   (ready),
      .pending (pending),
      .overrun (overrun),
      .clr_ovr (clr_ovr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a set of outstanding events, one presented index,
   // and the sticky overrun flag.
   bit m_prev  [N];
   bit m_pend  [N];
   bit m_valid;
   int m_code;
   bit m_ovr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_prev[i] = 1'b1;
         m_pend[i] = 1'b0;
      end
      m_valid = 1'b0;
      m_code  = 0;
      m_ovr   = 1'b0;
   endtask

   function automatic logic [N-1:0] m_pend_vec();
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = m_pend[i];
      return v;
   endfunction

   task automatic compare_all();
      chk("valid",   32'(valid),   32'(m_valid));
      chk("code",    32'(code),    32'(m_code));
      chk("pending", 32'(pending), 32'(m_pend_vec()));
      chk("overrun", 32'(overrun), 32'(m_ovr));
   endtask

   // One clock: compute the model's next state from the inputs present at the
   // edge, let the edge happen, then compare shortly after it.
   task automatic tick();
      bit nx_pend [N];
      bit taken;
      bit dup;
      bit nx_valid;
      int nx_code;
      int first;
      taken = m_valid && ready;
      dup   = 1'b0;
      for (int i = 0; i < N; i++) begin
         bit fresh, still;
         fresh = en && req[i] && !m_prev[i];
         still = m_pend[i] && !(taken && m_code == i);
         if (fresh && still) dup = 1'b1;
         nx_pend[i] = still || fresh;
      end
      nx_valid = m_valid;
      nx_code  = m_code;
      if (!m_valid || taken) begin
         first = -1;
         for (int i = 0; i < N; i++) begin
            if (first < 0 && m_pend[i] && !(taken && m_code == i)) first = i;
         end
         if (first >= 0) begin
            nx_valid = 1'b1;
            nx_code  = first;
         end else begin
            nx_valid = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         m_pend[i] = nx_pend[i];
         m_prev[i] = req[i];
      end
      m_valid = nx_valid;
      m_code  = nx_code;
      if (dup) m_ovr = 1'b1;
      else if (clr_ovr) m_ovr = 1'b0;
      compare_all();
   endtask

   initial begin
      n_chk   = 0;
      n_pass  = 0;
      rst_n   = 1'b0;
      req     = '1;
      en      = 1'b1;
      ready   = 1'b0;
      clr_ovr = 1'b0;
      model_reset();

      // Reset with all lines high; nothing may be reported afterwards.
      #12;
      compare_all();
      rst_n = 1'b1;
      repeat (5) tick();
      chk("hold_high_valid", 32'(valid), 32'd0);
      chk("hold_high_pend",  32'(pending), 32'h00);

      // Single pulse with idle consumer: pending at E0, code at E1, gone at E2.
      ready = 1'b1; req = 8'h00; tick();
      req = 8'h20; tick();
      chk("e0_pend",  32'(pending), 32'h20);
      chk("e0_valid", 32'(valid), 32'd0);
      req = 8'h00; tick();
      chk("e1_valid", 32'(valid), 32'd1);
      chk("e1_code",  32'(code), 32'd5);
      tick();
      chk("e2_valid", 32'(valid), 32'd0);
      chk("e2_pend",  32'(pending), 32'h00);

      // Simultaneous rises while stalled, then drain in priority order.
      ready = 1'b0; req = 8'h54; tick();
      req = 8'h00; tick(); tick(); tick();
      chk("stall_code", 32'(code), 32'd2);
      chk("stall_pend", 32'(pending), 32'h54);
      ready = 1'b1; tick();
      chk("drain_code4", 32'(code), 32'd4);
      tick();
      chk("drain_code6", 32'(code), 32'd6);
      tick();
      chk("drain_empty", 32'(valid), 32'd0);

      // Duplicate edge on the presented line while stalled.
      ready = 1'b0; req = 8'h08; tick();
      req = 8'h00; tick();
      chk("dup_code", 32'(code), 32'd3);
      req = 8'h08; tick();
      chk("dup_ovr",  32'(overrun), 32'd1);
      chk("dup_pend", 32'(pending), 32'h08);
      req = 8'h00; clr_ovr = 1'b1; tick();
      chk("ovr_clr", 32'(overrun), 32'd0);
      clr_ovr = 1'b0; ready = 1'b1; tick(); tick();

      // New edge on the line being accepted in the same cycle.
      req = 8'h02; tick();
      req = 8'h00; tick();
      chk("reacc_code", 32'(code), 32'd1);
      req = 8'h02; tick();
      chk("reacc_ovr",  32'(overrun), 32'd0);
      chk("reacc_pend", 32'(pending), 32'h02);
      req = 8'h00; tick();
      chk("reacc_again_valid", 32'(valid), 32'd1);
      chk("reacc_again_code",  32'(code), 32'd1);
      tick();

      // Enable gating: ignored edge, level without edge, then a real edge.
      en = 1'b0; req = 8'h01; tick(); tick();
      chk("en_off_pend", 32'(pending), 32'h00);
      en = 1'b1; tick(); tick();
      chk("level_no_evt", 32'(valid), 32'd0);
      req = 8'h00; tick();
      req = 8'h01; tick();
      req = 8'h00; tick();
      chk("en_on_code",  32'(code), 32'd0);
      chk("en_on_valid", 32'(valid), 32'd1);
      tick();

      // Asynchronous reset in the middle of a transfer.
      ready = 1'b0; req = 8'h0C; tick();
      req = 8'h00; tick();
      chk("pre_rst_pend", 32'(pending), 32'h0C);
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst_valid",   32'(valid), 32'd0);
      chk("arst_pend",    32'(pending), 32'h00);
      chk("arst_code",    32'(code), 32'd0);
      chk("arst_overrun", 32'(overrun), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) m_prev[i] = req[i];
      compare_all();

      // Random traffic against the model.
      for (int k = 0; k < 600; k++) begin
         req     = N'($urandom) & N'($urandom);
         en      = ($urandom_range(0, 9) != 0);
         ready   = ($urandom_range(0, 2) != 0);
         clr_ovr = ($urandom_range(0, 15) == 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
